hazard_fwd_unit: RTL and testbench

- Central stall and forwarding controller for the 5-stage pipelined MIPS core (F/D/E/M/W).
- Keeps a shadow pipeline of destination-register tags and Tnew counters for E, M and W, compared against the D-stage Tuse requirements.
- Drives the stall/bubble signals and the select codes for the forwarding multiplexers:
  - 3-input word mux on D-stage compare operands.
  - 3-input word mux on E-stage ALU operands.
  - 2-input word mux on M-stage store data.
- Also counts stall cycles for performance debug.

---
 rtl/hazard_fwd_unit.sv | 133 +++++++++++++
 tb/tb_hazard_fwd_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Stall and forwarding controller for the five-stage core.
// A shadow pipeline of register tags and Tnew counters (E, M, W) is compared
// against the D-stage Tuse requirements. From that comparison the block
// produces the stall and all forwarding mux selects combinationally.
// The only registered output is the stall-cycle counter.
module hazard_fwd_unit #(
    parameter int RegBit = 5,
    parameter int TBit   = 2,
    parameter int CntBit = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RegBit-1:0] D_rs,
    input  logic [RegBit-1:0] D_rt,
    input  logic [TBit-1:0]   D_Tuse_rs,
    input  logic [TBit-1:0]   D_Tuse_rt,
    input  logic [RegBit-1:0] D_dst,
    input  logic [TBit-1:0]   D_Tnew,
    input  logic              D_is_md,
    input  logic              md_busy,
    output logic              stall,
    output logic [1:0]        D_fwd_rs_sel,
    output logic [1:0]        D_fwd_rt_sel,
    output logic [1:0]        E_fwd_rs_sel,
    output logic [1:0]        E_fwd_rt_sel,
    output logic              M_fwd_rt_sel,
    output logic [CntBit-1:0] stall_cnt
);

    // Only the shadow fields that some compare actually reads are stored.
    // W_Tnew is always 0, and M_rs, W_rs and W_rt feed no select, so none of
    // these is kept.
    logic [RegBit-1:0] e_rs, e_rt, e_dst;
    logic [TBit-1:0]   e_tnew;
    logic [RegBit-1:0] m_rt, m_dst;
    logic [TBit-1:0]   m_tnew;
    logic [RegBit-1:0] w_dst;

    logic rs_stall, rt_stall;

    // A D-stage source hits a pending producer in E or M.
    function automatic logic src_stall(
        input logic [RegBit-1:0] src,
        input logic [TBit-1:0]   tuse,
        input logic [RegBit-1:0] ed,
        input logic [TBit-1:0]   et,
        input logic [RegBit-1:0] md,
        input logic [TBit-1:0]   mt
    );
        return (src != '0) &&
               (((src == ed) && (et > tuse)) || ((src == md) && (mt > tuse)));
    endfunction

    // D-stage compare operand select. The newest ready producer wins. W is
    // not a source here because the register file bypasses internally.
    function automatic logic [1:0] d_sel(
        input logic [RegBit-1:0] src,
        input logic [RegBit-1:0] ed,
        input logic [TBit-1:0]   et,
        input logic [RegBit-1:0] md,
        input logic [TBit-1:0]   mt
    );
        if (src == '0)                       return 2'b00;
        else if ((src == ed) && (et == '0))  return 2'b01;
        else if ((src == md) && (mt == '0))  return 2'b10;
        else                                 return 2'b00;
    endfunction

    // E-stage ALU operand select: a ready M result first, then W.
    function automatic logic [1:0] e_sel(
        input logic [RegBit-1:0] src,
        input logic [RegBit-1:0] md,
        input logic [TBit-1:0]   mt,
        input logic [RegBit-1:0] wd
    );
        if (src == '0)                       return 2'b00;
        else if ((src == md) && (mt == '0))  return 2'b01;
        else if (src == wd)                  return 2'b10;
        else                                 return 2'b00;
    endfunction

    // Hazard detection and forwarding selects, all same-cycle combinational.
    always_comb begin
        rs_stall     = src_stall(D_rs, D_Tuse_rs, e_dst, e_tnew, m_dst, m_tnew);
        rt_stall     = src_stall(D_rt, D_Tuse_rt, e_dst, e_tnew, m_dst, m_tnew);
        stall        = rs_stall || rt_stall || (D_is_md && md_busy);
        D_fwd_rs_sel = d_sel(D_rs, e_dst, e_tnew, m_dst, m_tnew);
        D_fwd_rt_sel = d_sel(D_rt, e_dst, e_tnew, m_dst, m_tnew);
        E_fwd_rs_sel = e_sel(e_rs, m_dst, m_tnew, w_dst);
        E_fwd_rt_sel = e_sel(e_rt, m_dst, m_tnew, w_dst);
        M_fwd_rt_sel = (m_rt != '0) && (m_rt == w_dst);
    end

    // The shadow pipeline advances every cycle. On a stall, E takes a bubble
    // while M and W keep draining.
    always_ff @(posedge clk) begin
        if (!reset) begin
            e_rs   <= '0;
            e_rt   <= '0;
            e_dst  <= '0;
            e_tnew <= '0;
            m_rt   <= '0;
            m_dst  <= '0;
            m_tnew <= '0;
            w_dst  <= '0;
        end else begin
            w_dst  <= m_dst;
            m_rt   <= e_rt;
            m_dst  <= e_dst;
            m_tnew <= (e_tnew == '0) ? '0 : e_tnew - TBit'(1);
            if (stall) begin
                e_rs   <= '0;
                e_rt   <= '0;
                e_dst  <= '0;
                e_tnew <= '0;
            end else begin
                e_rs   <= D_rs;
                e_rt   <= D_rt;
                e_dst  <= D_dst;
                e_tnew <= D_Tnew;
            end
        end
    end

    // Count stalled cycles for performance debug. The counter wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset)
            stall_cnt <= '0;
        else if (stall)
            stall_cnt <= stall_cnt + CntBit'(1);
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit. Inputs change 1 ns after the rising
// edge, and outputs are checked 1 ns later.
module tb_hazard_fwd_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt, D_dst;
    logic [1:0]  D_Tuse_rs, D_Tuse_rt, D_Tnew;
    logic        D_is_md, md_busy;
    logic        stall;
    logic [1:0]  D_fwd_rs_sel, D_fwd_rt_sel, E_fwd_rs_sel, E_fwd_rt_sel;
    logic        M_fwd_rt_sel;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_fwd_unit dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
        .D_dst(D_dst), .D_Tnew(D_Tnew), .D_is_md(D_is_md), .md_busy(md_busy),
        .stall(stall), .D_fwd_rs_sel(D_fwd_rs_sel), .D_fwd_rt_sel(D_fwd_rt_sel),
        .E_fwd_rs_sel(E_fwd_rs_sel), .E_fwd_rt_sel(E_fwd_rt_sel),
        .M_fwd_rt_sel(M_fwd_rt_sel), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                         input logic [4:0] dst, input logic [1:0] tnew,
                         input logic is_md, input logic busy);
        D_rs = rs; D_rt = rt; D_Tuse_rs = tu_rs; D_Tuse_rt = tu_rt;
        D_dst = dst; D_Tnew = tnew; D_is_md = is_md; md_busy = busy;
        #1;
    endtask

    task automatic nop_flush();
        drive(0, 0, 3, 3, 0, 0, 0, 0);
        repeat (3) step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(5, 0, 0, 3, 5, 1, 0, 0);
        repeat (3) step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b want 0", stall); end
        checks++; if ({D_fwd_rs_sel, D_fwd_rt_sel, E_fwd_rs_sel, E_fwd_rt_sel, M_fwd_rt_sel} !== 9'b0) begin
            errors++; $display("FAIL rst_sels: got %0h want 0", {D_fwd_rs_sel, D_fwd_rt_sel, E_fwd_rs_sel, E_fwd_rt_sel, M_fwd_rt_sel}); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", stall_cnt); end
        reset = 1'b1;
        step();
        // E now holds dst 5 with Tnew 1, and the D reader of $5 with Tuse 0 must stall.
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_release_e_dst: stall got %0b want 1", stall); end
        nop_flush();
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt_after: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_load_use();
        drive(9, 0, 1, 3, 8, 2, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_lw_issue: stall got %0b want 0", stall); end
        step();
        drive(8, 0, 1, 3, 10, 1, 0, 0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b want 1", stall); end
        step();
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release: stall got %0b want 0", stall); end
        checks++; if (D_fwd_rs_sel !== 2'b00) begin errors++; $display("FAIL lu_dsel_notready: got %0b want 00", D_fwd_rs_sel); end
        step();
        checks++; if (E_fwd_rs_sel !== 2'b10) begin errors++; $display("FAIL lu_esel_w: got %0b want 10", E_fwd_rs_sel); end
        nop_flush();
    endtask

    task automatic test_alu_alu();
        drive(1, 2, 1, 1, 3, 1, 0, 0);
        step();
        drive(3, 0, 1, 3, 6, 1, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL aa_stall: got %0b want 0", stall); end
        checks++; if (D_fwd_rs_sel !== 2'b00) begin errors++; $display("FAIL aa_dsel: got %0b want 00", D_fwd_rs_sel); end
        step();
        checks++; if (E_fwd_rs_sel !== 2'b01) begin errors++; $display("FAIL aa_esel_rs: got %0b want 01", E_fwd_rs_sel); end
        checks++; if (E_fwd_rt_sel !== 2'b00) begin errors++; $display("FAIL aa_esel_rt: got %0b want 00", E_fwd_rt_sel); end
        nop_flush();
    endtask

    task automatic test_branch();
        drive(1, 2, 1, 1, 4, 1, 0, 0);
        step();
        drive(4, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL br_stall: got %0b want 1", stall); end
        step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL br_release: got %0b want 0", stall); end
        checks++; if (D_fwd_rs_sel !== 2'b10) begin errors++; $display("FAIL br_dsel_m: got %0b want 10", D_fwd_rs_sel); end
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL br_cnt: got %0d want 2", stall_cnt); end
        nop_flush();
    endtask

    task automatic test_zero_priority();
        drive(1, 2, 1, 1, 0, 1, 0, 0);
        step();
        drive(0, 0, 0, 0, 5, 1, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL z_stall: got %0b want 0", stall); end
        checks++; if ({D_fwd_rs_sel, D_fwd_rt_sel} !== 4'b0) begin errors++; $display("FAIL z_dsel_e: got %0b want 0000", {D_fwd_rs_sel, D_fwd_rt_sel}); end
        step();
        checks++; if ({D_fwd_rs_sel, D_fwd_rt_sel} !== 4'b0) begin errors++; $display("FAIL z_dsel_m: got %0b want 0000", {D_fwd_rs_sel, D_fwd_rt_sel}); end
        checks++; if ({E_fwd_rs_sel, E_fwd_rt_sel} !== 4'b0) begin errors++; $display("FAIL z_esel: got %0b want 0000", {E_fwd_rs_sel, E_fwd_rt_sel}); end
        nop_flush();
        // Two ALU writers of $7, then a reader.
        drive(1, 2, 1, 1, 7, 1, 0, 0);
        step();
        drive(1, 2, 1, 1, 7, 1, 0, 0);
        step();
        drive(7, 7, 1, 1, 9, 1, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL pr_stall: got %0b want 0", stall); end
        checks++; if (D_fwd_rs_sel !== 2'b10) begin errors++; $display("FAIL pr_dsel: got %0b want 10", D_fwd_rs_sel); end
        step();
        checks++; if (E_fwd_rs_sel !== 2'b01) begin errors++; $display("FAIL pr_esel_rs: got %0b want 01", E_fwd_rs_sel); end
        checks++; if (E_fwd_rt_sel !== 2'b01) begin errors++; $display("FAIL pr_esel_rt: got %0b want 01", E_fwd_rt_sel); end
        nop_flush();
        // Two link-style writers of $7 (both ready), so the D select must pick E over M.
        drive(0, 0, 3, 3, 7, 0, 0, 0);
        step();
        drive(0, 0, 3, 3, 7, 0, 0, 0);
        step();
        drive(7, 0, 0, 3, 0, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL pr_link_stall: got %0b want 0", stall); end
        checks++; if (D_fwd_rs_sel !== 2'b01) begin errors++; $display("FAIL pr_link_dsel: got %0b want 01", D_fwd_rs_sel); end
        nop_flush();
    endtask

    task automatic test_md_busy();
        drive(0, 0, 3, 3, 12, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL md_stall[%0d]: got %0b want 1", i, stall); end
            step();
        end
        md_busy = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL md_release: got %0b want 0", stall); end
        checks++; if (stall_cnt !== 32'd6) begin errors++; $display("FAIL md_cnt: got %0d want 6", stall_cnt); end
        drive(12, 0, 0, 3, 0, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL md_bubble: got %0b want 0", stall); end
        nop_flush();
    endtask

    task automatic test_store_after_load();
        drive(9, 0, 1, 3, 8, 2, 0, 0);
        step();
        drive(9, 8, 1, 2, 0, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL st_stall: got %0b want 0", stall); end
        step();
        drive(0, 0, 3, 3, 0, 0, 0, 0);
        checks++; if (E_fwd_rt_sel !== 2'b00) begin errors++; $display("FAIL st_esel_rt: got %0b want 00", E_fwd_rt_sel); end
        checks++; if (M_fwd_rt_sel !== 1'b0) begin errors++; $display("FAIL st_msel_early: got %0b want 0", M_fwd_rt_sel); end
        step();
        checks++; if (M_fwd_rt_sel !== 1'b1) begin errors++; $display("FAIL st_msel: got %0b want 1", M_fwd_rt_sel); end
        nop_flush();
    endtask

    task automatic test_reset_mid_stall();
        drive(9, 0, 1, 3, 8, 2, 0, 0);
        step();
        drive(8, 0, 1, 3, 10, 1, 0, 0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rms_stall: got %0b want 1", stall); end
        reset = 1'b0;
        step();
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rms_cnt: got %0d want 0", stall_cnt); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rms_cleared: got %0b want 0", stall); end
        reset = 1'b1;
        step();
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rms_cnt_after: got %0d want 0", stall_cnt); end
        nop_flush();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_alu_alu();
        test_branch();
        test_zero_priority();
        test_md_busy();
        test_store_after_load();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
